alu_divider: RTL and testbench

- Iterative multi-cycle integer divider: the inverse counterpart to the single-cycle ALU multiply path.
- Computes quotient and remainder of a / b, signed or unsigned, using a restoring shift-subtract loop at one bit per cycle.
- Sits beside the ALU in the CPU execute stage. The stall logic holds the pipeline while busy is high and samples results on done.

---
 rtl/alu_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/alu_divider.sv | 114 +++++++++++
 tb/tb_alu_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU divider: state encoding, default width
// and the divide-by-zero quotient pattern.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // All-ones pattern wide enough for any supported WIDTH; callers slice it down.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor, keep the difference and shift in a 1 when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);

  logic        [WIDTH:0] rem_sh;
  logic signed [WIDTH:0] trial;

  // rem < divisor on entry, so WIDTH+1 bits hold the shifted value and the sign of the difference.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    trial  = $signed(rem_sh - {1'b0, divisor});
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      dvd_next = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      dvd_next = {dvd[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_divider.sv
// Iterative signed/unsigned divider, one quotient bit per cycle (restoring).
// Optional macro ALU_DIVIDER_EARLY_OUT_EN: skip the loop when b = 0 or |a| < |b|.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q, a_orig_q;
  logic             q_neg_q, r_neg_q, b_zero_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_dvd;
  logic             accept, take_early;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign abs_a  = magnitude(a, sig);
  assign abs_b  = magnitude(b, sig);
  assign accept = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  always_comb begin
    take_early = 1'b0;
`ifdef ALU_DIVIDER_EARLY_OUT_EN
    take_early = (b == '0) || (abs_a < abs_b);
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dsr_q),
    .rem_next (step_rem),
    .dvd_next (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = take_early ? FIX : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural outputs: cleared by reset, results written in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(WIDTH);
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == FIX) begin
        quotient  <= b_zero_q ? DIV0_QUOTIENT[WIDTH-1:0] : apply_sign(dvd_q, q_neg_q);
        remainder <= b_zero_q ? a_orig_q : apply_sign(rem_q, r_neg_q);
      end
    end
  end

  // Datapath: operands latched on accept, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dsr_q    <= abs_b;
      a_orig_q <= a;
      q_neg_q  <= sig & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_q  <= sig & a[WIDTH-1];
      b_zero_q <= (b == '0);
      if (take_early) begin
        dvd_q <= '0;
        rem_q <= abs_a;
      end else begin
        dvd_q <= abs_a;
        rem_q <= '0;
      end
    end else if (state_q == CALC) begin
      rem_q <= step_rem;
      dvd_q <= step_dvd;
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: a reference process queues expected results
// on each accepted start; a monitor checks busy/done timing and outputs every cycle.
`timescale 1ns/1ps
module tb_alu_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sig = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done;

  always #5 clk = ~clk;

  alu_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .sig       (sig),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sig;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  res_t         sb[$];
  vec_t         vt[14];

  int           edge_n = 0;
  int           free_edge = 0;
  int           busy_last = -1;
  int           done_edge = -1;
  int           last_rst_edge = -1;
  int           lat;
  bit           armed = 0;
  logic [W-1:0] cur_q = '0;
  logic [W-1:0] cur_r = '0;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;
  res_t         popped;
  bit           end_req = 0;
  bit           end_done = 0;

  function automatic bit early_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
`ifdef ALU_DIVIDER_EARLY_OUT_EN
    logic [W-1:0] mx, my;
    mx = (s && x[W-1]) ? -x : x;
    my = (s && y[W-1]) ? -y : y;
    return (y == '0) || (mx < my);
`else
    return 1'b0;
`endif
  endfunction

  // Reference timing: accepted when idle, done in the period after edge E+lat-1.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (reset) begin
      sb.delete();
      busy_last     = -1;
      done_edge     = -1;
      free_edge     = edge_n + 1;
      last_rst_edge = edge_n;
      armed         = 1;
    end else if (start && edge_n >= free_edge) begin
      lat       = early_of(a, b, sig) ? 2 : W + 2;
      busy_last = edge_n + lat - 1;
      done_edge = busy_last;
      free_edge = edge_n + lat + 1;
      sb.push_back('{q: cur_q, r: cur_r});
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (last_rst_edge == edge_n) begin
        exp_q = '0;
        exp_r = '0;
      end
      checks++;
      if (busy !== (edge_n <= busy_last)) begin
        errors++;
        $display("FAIL busy at edge %0d: got %b want %b", edge_n, busy, (edge_n <= busy_last));
      end
      checks++;
      if (done !== (edge_n == done_edge)) begin
        errors++;
        $display("FAIL done at edge %0d: got %b want %b", edge_n, done, (edge_n == done_edge));
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at edge %0d: got pulse want none", edge_n);
        end else begin
          popped = sb.pop_front();
          exp_q  = popped.q;
          exp_r  = popped.r;
        end
      end
      checks++;
      if (quotient !== exp_q) begin
        errors++;
        $display("FAIL quotient at edge %0d: got %h want %h", edge_n, quotient, exp_q);
      end
      checks++;
      if (remainder !== exp_r) begin
        errors++;
        $display("FAIL remainder at edge %0d: got %h want %h", edge_n, remainder, exp_r);
      end
      if (end_req && !end_done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL pending_results: got %0d outstanding want 0", sb.size());
        end
        end_done = 1;
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    a     = v.a;
    b     = v.b;
    sig   = v.sig;
    cur_q = v.q;
    cur_r = v.r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 || done !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL idle_timeout: got busy=%b want 0 within 200 cycles", busy);
        $fatal(1, "divider never returned to idle");
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vt[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE};
    vt[2]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2};
    vt[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE};
    vt[4]  = '{32'h12345678,   32'h0,          1'b0, 32'hFFFFFFFF,   32'h12345678};
    vt[5]  = '{32'h12345678,   32'h0,          1'b1, 32'hFFFFFFFF,   32'h12345678};
    vt[6]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0};
    vt[7]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'h0};
    vt[8]  = '{32'hFFFFFF9C,   32'd7,          1'b0, 32'h24924916,   32'd2};
    vt[9]  = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5};
    vt[10] = '{32'hFFFFFFF9,   32'd100,        1'b1, 32'd0,          32'hFFFFFFF9};
    vt[11] = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0};
    vt[12] = '{32'h80000000,   32'h0,          1'b1, 32'hFFFFFFFF,   32'h80000000};
    vt[13] = '{32'd7,          32'd7,          1'b0, 32'd1,          32'd0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      issue(vt[i]);
      wait_idle();
    end

    // Abort scenario: second start while busy is ignored, reset discards the operation.
    issue('{32'd50, 32'd5, 1'b0, 32'd10, 32'd0});
    repeat (8) @(negedge clk);
    a = 32'd9; b = 32'd3; sig = 1'b0; cur_q = 32'd3; cur_r = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    issue('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0});
    wait_idle();

    // Back-to-back with start held high.
    @(negedge clk);
    a = 32'd100; b = 32'd7; sig = 1'b0; cur_q = 32'd14; cur_r = 32'd2;
    start = 1'b1;
    repeat (3 * (W + 3) + 4) @(negedge clk);
    start = 1'b0;
    wait_idle();

    @(negedge clk);
    a = 32'd5; b = 32'd9; sig = 1'b0; cur_q = 32'd0; cur_r = 32'd5;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_idle();

    end_req = 1;
    for (int k = 0; k < 5 && !end_done; k++) @(negedge clk);
    if (!end_done) begin
      $display("FAIL end_check: got no final check want one");
      $fatal(1, "final scoreboard check not reached");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
